// File: rtl/req_router.sv
// req_router: address-decoded request router with bus-error, interrupt and fault capture
module req_router #(
    parameter int                        SLAVES   = 4,
    parameter int                        SEL_W    = 4,
    parameter int                        SEL_LO   = 28,
    parameter logic [SLAVES*SEL_W-1:0]   MAP      = 16'hF210,
    parameter int                        TIMEOUT  = 1024,
    parameter logic [31:0]               ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic [2:0]           req_len,
    input  logic                 req_we,
    input  logic                 write_valid,
    output logic                 read_valid,
    output logic [31:0]          read_data,
    input  logic                 read_ack,
    output logic [SLAVES-1:0]    slv_req_valid,
    input  logic [SLAVES-1:0]    slv_req_ready,
    output logic [SLAVES-1:0]    slv_write_valid,
    input  logic [SLAVES-1:0]    slv_read_valid,
    input  logic [32*SLAVES-1:0] slv_read_data,
    output logic [SLAVES-1:0]    slv_read_ack,
    output logic                 bus_err,
    output logic                 err_irq,
    output logic [31:0]          err_addr
);
    localparam int SW = SLAVES > 1 ? $clog2(SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);
    localparam logic [SLAVES-1:0] ONE = SLAVES'(1);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     sel, dec_sel;
    logic              hit, dec_hit, we, err, event_now;
    logic [2:0]        len, beat;
    logic [TW-1:0]     tcnt;
    logic [31:0]       addr;
    logic [SLAVES-1:0] sel_oh;

    assign sel_oh = ONE << sel;

    // lowest-index map entry matching the address field wins
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = SLAVES - 1; i >= 0; i--)
            if (req_addr[SEL_LO +: SEL_W] == MAP[i*SEL_W +: SEL_W]) begin
                dec_sel = SW'(i);
                dec_hit = 1'b1;
            end
    end

    // next state and all handshake routing; the router answers misses and hung slaves itself
    always_comb begin
        state_nx        = state;
        req_ready       = 1'b0;
        slv_req_valid   = '0;
        slv_write_valid = '0;
        slv_read_ack    = '0;
        read_valid      = 1'b0;
        read_data       = '0;
        bus_err         = 1'b0;
        err_irq         = 1'b0;
        event_now       = 1'b0;
        case (state)
            IDLE: state_nx = req_valid ? REQ : IDLE;
            REQ: begin
                slv_req_valid = hit ? sel_oh : '0;
                event_now     = hit && slv_req_ready[sel];
                err_irq       = !hit || (!event_now && tcnt == T_END);
                req_ready     = event_now || err_irq;
                state_nx      = req_ready ? DATA : REQ;
            end
            DATA: begin
                if (we) begin
                    slv_write_valid = (write_valid && !err) ? sel_oh : '0;
                    bus_err         = write_valid && err;
                    event_now       = write_valid;
                end else begin
                    read_valid   = err || slv_read_valid[sel];
                    read_data    = err ? ERR_DATA : slv_read_valid[sel] ? slv_read_data[32*sel +: 32] : '0;
                    slv_read_ack = (read_ack && !err) ? sel_oh : '0;
                    bus_err      = err;
                    event_now    = read_valid && read_ack;
                end
                err_irq  = !err && !event_now && tcnt == T_END;
                state_nx = (event_now && beat == len) ? IDLE : DATA;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register plus per-transaction context captured at decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            hit   <= 1'b0;
            we    <= 1'b0;
            len   <= '0;
            addr  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                sel  <= dec_sel;
                hit  <= dec_hit;
                we   <= req_we;
                len  <= req_len;
                addr <= req_addr;
            end
        end
    end

    // beat counter, saturating idle-cycle counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
            tcnt <= '0;
            err  <= 1'b0;
        end else if (state == IDLE) begin
            beat <= '0;
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            beat <= (state == REQ) ? '0 : event_now ? beat + 3'd1 : beat;
            tcnt <= (event_now || req_ready) ? '0 : (tcnt == T_END) ? tcnt : tcnt + 1'b1;
            err  <= err || err_irq;
        end
    end

    // fault address of the most recent errored transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_addr <= '0;
        else if (err_irq) err_addr <= addr;
    end
endmodule

// File: tb/tb_req_router.sv
// tb_req_router: randomized and directed scenarios checked against a transaction-level model
module tb_req_router;
    localparam int SLAVES = 4;
    localparam int TIMEOUT = 16;
    localparam logic [15:0] MAP = 16'hF210;
    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid, req_ready, req_we, write_valid, read_valid, read_ack;
    logic [31:0]          req_addr, read_data, err_addr;
    logic [2:0]           req_len;
    logic [SLAVES-1:0]    slv_req_valid, slv_req_ready, slv_write_valid, slv_read_valid, slv_read_ack;
    logic [32*SLAVES-1:0] slv_read_data;
    logic                 bus_err, err_irq;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_err_addr = '0;

    req_router #(
        .SLAVES(SLAVES), .SEL_W(4), .SEL_LO(28), .MAP(MAP), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len), .req_we(req_we),
        .write_valid(write_valid), .read_valid(read_valid), .read_data(read_data), .read_ack(read_ack),
        .slv_req_valid(slv_req_valid), .slv_req_ready(slv_req_ready), .slv_write_valid(slv_write_valid),
        .slv_read_valid(slv_read_valid), .slv_read_data(slv_read_data), .slv_read_ack(slv_read_ack),
        .bus_err(bus_err), .err_irq(err_irq), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    function automatic int exp_sel(input logic [31:0] a);
        logic [15:0] m;
        m = MAP;
        for (int i = 0; i < SLAVES; i++)
            if (a[31:28] == m[i*4 +: 4]) return i;
        return -1;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_addr = '0; req_len = '0; req_we = 0; write_valid = 0; read_ack = 0;
        slv_req_ready = '0; slv_read_valid = '0; slv_read_data = '0;
    endtask

    task automatic check_quiet(input string name);
        tests_run++;
        if ({req_ready, read_valid, bus_err, err_irq} !== 4'b0 || (slv_req_valid | slv_write_valid | slv_read_ack) !== '0
            || read_data !== '0 || err_addr !== '0) begin
            tests_failed++;
            $display("FAIL %s: got rdy=%b rv=%b be=%b irq=%b strobes=%b/%b/%b rd=%h ea=%h required all zero",
                     name, req_ready, read_valid, bus_err, err_irq, slv_req_valid, slv_write_valid, slv_read_ack,
                     read_data, err_addr);
        end
    endtask

    // one master transaction against a scripted slave; expectations come from the router's rules
    task automatic run_txn(input string name, input logic [31:0] addr, input logic [2:0] len, input logic we,
                           input int dly, input int stall_beat, input int stall_len, input bit rnd);
        int s = exp_sel(addr);
        int nb = int'(len) + 1;
        int gap[8];
        logic [31:0] data[8];
        logic [31:0] exp_d;
        logic [SLAVES-1:0] mask;
        bit req_err, err_any, exp_e;
        int first_err, exp_rdy;
        int cyc = 0, seen = 0, sbeat = 0, scnt, wgap, got = 0, sent = 0, irq_cnt = 0, wr_pulses = 0;
        bit acc = 0, hs = 0, err_seen = 0, pres;
        for (int b = 0; b < 8; b++) begin
            gap[b] = rnd ? int'($urandom_range(0, 3)) : 0;
            if (b == stall_beat) gap[b] = stall_len;
            data[b] = rnd ? $urandom : 32'hA0 + b;
        end
        req_err = (s < 0) || (dly >= TIMEOUT);
        first_err = req_err ? 0 : nb;
        if (!we && !req_err)
            for (int b = nb - 1; b >= 0; b--) if (gap[b] >= TIMEOUT) first_err = b;
        err_any = we ? req_err : (first_err < nb);
        exp_rdy = (s < 0) ? 1 : 1 + ((dly < TIMEOUT - 1) ? dly : TIMEOUT - 1);
        scnt = gap[0];
        wgap = gap[0];
        while (!(we ? sent == nb : got == nb) && cyc < 300) begin
            @(posedge clk); #1;
            req_valid = !acc; req_addr = addr; req_len = len; req_we = we;
            slv_req_ready = '0; slv_read_valid = '0; slv_read_data = '0; write_valid = 0;
            read_ack = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pres = 0;
            if (s >= 0 && !hs && seen >= dly) slv_req_ready[s] = 1'b1;
            if (s >= 0 && hs && !we && sbeat < nb && scnt == 0) begin
                slv_read_valid[s] = 1'b1;
                slv_read_data[s*32 +: 32] = data[sbeat];
                pres = 1;
            end
            if (acc && we && sent < nb && wgap == 0) write_valid = 1;
            #4;
            mask = (s >= 0 && !err_seen) ? (4'b0001 << s) : 4'b0000;
            tests_run++;
            if (((slv_req_valid | slv_write_valid | slv_read_ack) & ~mask) !== '0) begin
                tests_failed++;
                $display("FAIL %s strobes cyc %0d: got %b/%b/%b allowed %b", name, cyc,
                         slv_req_valid, slv_write_valid, slv_read_ack, mask);
            end
            tests_run++;
            if (req_ready !== (cyc == exp_rdy)) begin
                tests_failed++;
                $display("FAIL %s req_ready cyc %0d: got %b required %b", name, cyc, req_ready, cyc == exp_rdy);
            end
            if (req_err || !err_any) begin
                tests_run++;
                if (err_irq !== (req_err && cyc == exp_rdy)) begin
                    tests_failed++;
                    $display("FAIL %s err_irq cyc %0d: got %b required %b", name, cyc, err_irq, req_err && cyc == exp_rdy);
                end
            end
            tests_run++;
            if (!read_valid && read_data !== '0) begin
                tests_failed++;
                $display("FAIL %s idle_data cyc %0d: got %h required 0", name, cyc, read_data);
            end
            if (we) begin
                tests_run++;
                if (read_valid !== 0 || bus_err !== (write_valid && req_err)) begin
                    tests_failed++;
                    $display("FAIL %s write_err cyc %0d: got rv=%b be=%b required rv=0 be=%b", name, cyc,
                             read_valid, bus_err, write_valid && req_err);
                end
                if (s >= 0 && slv_write_valid[s]) wr_pulses++;
            end else begin
                tests_run++;
                if (bus_err !== (read_valid && got >= first_err)) begin
                    tests_failed++;
                    $display("FAIL %s read_err cyc %0d: got %b required %b", name, cyc, bus_err, read_valid && got >= first_err);
                end
                if (read_valid && read_ack) begin
                    exp_d = (got < first_err) ? data[got] : ERR_DATA;
                    exp_e = got >= first_err;
                    tests_run++;
                    if (read_data !== exp_d || bus_err !== exp_e) begin
                        tests_failed++;
                        $display("FAIL %s beat %0d: got %h/%b required %h/%b", name, got, read_data, bus_err, exp_d, exp_e);
                    end
                    got++;
                end
            end
            if (pres) begin
                if (slv_read_ack[s]) begin
                    sbeat++;
                    scnt = (sbeat < 8) ? gap[sbeat] : 0;
                end
            end else if (hs && scnt > 0) scnt--;
            if (write_valid) begin
                sent++;
                wgap = (sent < 8) ? gap[sent] : 0;
            end else if (acc && wgap > 0) wgap--;
            if (s >= 0 && slv_req_valid[s]) seen++;
            if (s >= 0 && slv_req_valid[s] && slv_req_ready[s]) hs = 1;
            if (req_ready) acc = 1;
            if (err_irq) begin
                irq_cnt++;
                err_seen = 1;
            end
            cyc++;
        end
        tests_run++;
        if (!(we ? sent == nb : got == nb)) begin
            tests_failed++;
            $display("FAIL %s completion: got %0d beats required %0d within bound", name, we ? sent : got, nb);
            rst = 1; #1 idle_inputs(); @(posedge clk); #3 rst = 0;
            exp_err_addr = '0;
            return;
        end
        if (err_any) exp_err_addr = addr;
        tests_run++;
        if (irq_cnt != (err_any ? 1 : 0) || err_addr !== exp_err_addr) begin
            tests_failed++;
            $display("FAIL %s fault: got irqs=%0d addr=%h required irqs=%0d addr=%h", name, irq_cnt, err_addr,
                     err_any ? 1 : 0, exp_err_addr);
        end
        if (we && s >= 0) begin
            tests_run++;
            if (wr_pulses != (req_err ? 0 : nb)) begin
                tests_failed++;
                $display("FAIL %s write_pulses: got %0d required %0d", name, wr_pulses, req_err ? 0 : nb);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        req_valid = 1;
        req_addr = 32'h1000_0000;
        repeat (2) @(posedge clk);
        #3 check_quiet("reset");
        req_valid = 0;
        rst = 0;
    endtask

    task automatic test_read_slave1();
        run_txn("read_s1", 32'h1000_0040, 3'd3, 1'b0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_write_slave0();
        run_txn("write_s0", 32'h0000_0100, 3'd0, 1'b1, 3, -1, 0, 1'b0);
    endtask

    task automatic test_unmapped();
        run_txn("unmapped_rd", 32'h5000_0000, 3'd3, 1'b0, 0, -1, 0, 1'b0);
        run_txn("unmapped_wr", 32'h7000_0010, 3'd2, 1'b1, 0, -1, 0, 1'b0);
    endtask

    task automatic test_timeouts();
        run_txn("req_timeout", 32'h2000_0000, 3'd1, 1'b0, 1000, -1, 0, 1'b0);
        run_txn("ready_at_terminal", 32'hF000_0004, 3'd0, 1'b1, TIMEOUT - 1, -1, 0, 1'b0);
        run_txn("data_timeout", 32'h1000_0000, 3'd3, 1'b0, 0, 2, TIMEOUT, 1'b0);
        run_txn("beat_at_terminal", 32'hF000_0000, 3'd3, 1'b0, 0, 2, TIMEOUT - 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int got = 0;
        bit hs = 0, acc = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(posedge clk); #1;
            req_valid = !acc; req_addr = 32'h1000_0000; req_len = 3'd3; req_we = 0; read_ack = 1; write_valid = 0;
            slv_req_ready = hs ? 4'b0000 : 4'b0010;
            slv_read_valid = hs ? 4'b0010 : 4'b0000;
            slv_read_data = '0;
            slv_read_data[63:32] = 32'hB0 + got;
            #4;
            if (req_ready) acc = 1;
            if (read_valid && read_ack) got++;
            if (slv_req_valid[1] && slv_req_ready[1]) hs = 1;
        end
        @(posedge clk); #1;
        req_valid = 0;
        slv_read_valid = 4'b0010;
        slv_read_data[63:32] = 32'hB2;
        #1;
        tests_run++;
        if (read_valid !== 1'b1 || read_data !== 32'hB2) begin
            tests_failed++;
            $display("FAIL reset_mid_beat: got %b/%h required 1/000000b2", read_valid, read_data);
        end
        rst = 1;
        #1 check_quiet("reset_mid");
        idle_inputs();
        exp_err_addr = '0;
        repeat (2) @(posedge clk);
        #3 rst = 0;
        run_txn("after_reset", 32'h1000_0080, 3'd1, 1'b0, 1, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] fields[6];
        logic [31:0] a;
        fields = '{4'h0, 4'h1, 4'h2, 4'hF, 4'h5, 4'h7};
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            a[31:28] = fields[$urandom_range(0, 5)];
            run_txn("random", a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)), -1, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_read_slave1();
        test_write_slave0();
        test_unmapped();
        test_timeouts();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
